// File: rtl/tsm_pkg.sv
// Shared types and helpers for the traffic signal monitor.
// The optional watchdog is enabled by defining TSM_WATCHDOG_EN.
package tsm_pkg;

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StFault,
    StClear
  } state_e;

  // Controller signal codes
  localparam logic [1:0] C_GREEN  = 2'd0;
  localparam logic [1:0] C_AMBER  = 2'd1;
  localparam logic [1:0] C_RED    = 2'd2;
  localparam logic [1:0] C_REDAMB = 2'd3;

  // Latched fault causes
  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_CONFLICT = 2'd1;
  localparam logic [1:0] FC_ILLEGAL  = 2'd2;
  localparam logic [1:0] FC_WATCHDOG = 2'd3;

  // Lamp drives as {red, amber, green}
  localparam logic [2:0] LAMP_RED   = 3'b100;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_OFF   = 3'b000;

  function automatic logic [2:0] lamp_of(input logic [1:0] code);
    logic [2:0] lamp;
    unique case (code)
      C_GREEN:  lamp = 3'b001;
      C_AMBER:  lamp = 3'b010;
      C_RED:    lamp = 3'b100;
      default:  lamp = 3'b110;
    endcase
    return lamp;
  endfunction

  // Only legal non-holding step from each code
  function automatic logic [1:0] successor(input logic [1:0] code);
    logic [1:0] nxt;
    unique case (code)
      C_RED:    nxt = C_REDAMB;
      C_REDAMB: nxt = C_GREEN;
      C_GREEN:  nxt = C_AMBER;
      default:  nxt = C_RED;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tsm_head_check.sv
// Per-head checker: remembers the previous code while in service and flags
// open aspects and illegal sequence steps. Decoded lamp is combinational;
// the top level registers it. With TSM_WATCHDOG_EN a change flag is exported.
module tsm_head_check
  import tsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       prev_valid,
  input  logic [1:0] code,
`ifdef TSM_WATCHDOG_EN
  output logic       changed,
`endif
  output logic       is_open,
  output logic       illegal,
  output logic [2:0] lamp
);

  logic [1:0] prev_q;

  // Previous code tracks the input every cycle the monitor is in service
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= C_RED;
    end else if (load) begin
      prev_q <= code;
    end
  end

  // Aspect classification and step legality against the remembered code
  always_comb begin
    is_open = (code == C_GREEN) || (code == C_AMBER);
    illegal = prev_valid && (prev_q != code) && (code != successor(prev_q));
    lamp    = lamp_of(code);
  end

`ifdef TSM_WATCHDOG_EN
  // Any movement of this head restarts the watchdog
  always_comb begin
    changed = prev_valid && (prev_q != code);
  end
`endif

endmodule

// File: rtl/traffic_signal_monitor.sv
// Safety stage between the light controller and the lamp heads: decodes the
// four codes, latches a flashing-amber failsafe on conflict or illegal steps
// and only returns to service through an all-red clearance interval.
// Define TSM_WATCHDOG_EN to also fault when no code moves for WDOG_TICKS ticks.
module traffic_signal_monitor
  import tsm_pkg::*;
#(
  parameter int unsigned STARTUP_TICKS = 3,
  parameter int unsigned WDOG_TICKS    = 120,
  parameter int unsigned TICK_CNT_W    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] hw1_code,
  input  logic [1:0] hw2_code,
  input  logic [1:0] fm1_code,
  input  logic [1:0] fm2_code,
  input  logic       fault_clr,
  output logic [2:0] hw1_lamp,
  output logic [2:0] hw2_lamp,
  output logic [2:0] fm1_lamp,
  output logic [2:0] fm2_lamp,
  output logic       hold_req,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int unsigned MaxTicks = (STARTUP_TICKS > WDOG_TICKS) ? STARTUP_TICKS : WDOG_TICKS;

  // Reject a counter too narrow to reach the largest terminal count
  if (MaxTicks >= (1 << TICK_CNT_W)) begin : g_cnt_width_check
    $error("TICK_CNT_W too small for STARTUP_TICKS/WDOG_TICKS");
  end

  state_e                  state_q, state_d;
  logic [TICK_CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic                    prev_valid_q, prev_valid_d;
  logic                    flash_q, flash_d;
  logic                    fault_q, fault_d;
  logic [1:0]              fcode_q, fcode_d;
  logic                    hold_q, hold_d;
  logic [3:0][2:0]         lamp_q, lamp_d;
  logic [1:0]              detect;

  logic [3:0][1:0]         codes;
  logic [3:0]              opens;
  logic [3:0]              illegals;
  logic [3:0][2:0]         dec_lamps;
  logic                    conflict;
`ifdef TSM_WATCHDOG_EN
  logic [3:0]              changes;
`endif

  assign codes = {fm2_code, fm1_code, hw2_code, hw1_code};

  for (genvar i = 0; i < 4; i++) begin : g_head
    tsm_head_check u_head (
      .clk        (clk),
      .rst        (rst),
      .load       (state_q == StRun),
      .prev_valid (prev_valid_q),
      .code       (codes[i]),
`ifdef TSM_WATCHDOG_EN
      .changed    (changes[i]),
`endif
      .is_open    (opens[i]),
      .illegal    (illegals[i]),
      .lamp       (dec_lamps[i])
    );
  end

  // Any highway head open together with any farm head open
  assign conflict = (opens[0] | opens[1]) & (opens[2] | opens[3]);

  // Next-state, counters, fault latch and registered output values
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prev_valid_d = prev_valid_q;
    flash_d      = flash_q;
    fault_d      = fault_q;
    fcode_d      = fcode_q;
    hold_d       = 1'b1;
    lamp_d       = {4{LAMP_RED}};
    detect       = FC_NONE;
    cnt_inc      = cnt_q + TICK_CNT_W'(tick);

    unique case (state_q)
      StInit, StClear: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= TICK_CNT_W'(STARTUP_TICKS)) begin
          state_d      = StRun;
          cnt_d        = '0;
          prev_valid_d = 1'b0;
          fault_d      = 1'b0;
          fcode_d      = FC_NONE;
          hold_d       = 1'b0;
        end
      end

      StRun: begin
        hold_d       = 1'b0;
        prev_valid_d = 1'b1;
        lamp_d       = dec_lamps;
`ifdef TSM_WATCHDOG_EN
        cnt_d = (|changes) ? '0 : cnt_inc;
`endif
        if (conflict) begin
          detect = FC_CONFLICT;
        end else if (|illegals) begin
          detect = FC_ILLEGAL;
`ifdef TSM_WATCHDOG_EN
        end else if (cnt_d == TICK_CNT_W'(WDOG_TICKS)) begin
          detect = FC_WATCHDOG;
`endif
        end
        if (detect != FC_NONE) begin
          // The detecting cycle's lamps are already forced red
          state_d = StFault;
          fault_d = 1'b1;
          fcode_d = detect;
          hold_d  = 1'b1;
          flash_d = 1'b1;
          lamp_d  = {4{LAMP_RED}};
        end
      end

      StFault: begin
        flash_d = flash_q ^ tick;
        lamp_d  = flash_d ? {4{LAMP_AMBER}} : {4{LAMP_OFF}};
        if (fault_clr) begin
          state_d = StClear;
          cnt_d   = TICK_CNT_W'(tick);
          lamp_d  = {4{LAMP_RED}};
        end
      end

      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInit;
      cnt_q        <= '0;
      prev_valid_q <= 1'b0;
      flash_q      <= 1'b1;
      fault_q      <= 1'b0;
      fcode_q      <= FC_NONE;
      hold_q       <= 1'b1;
      lamp_q       <= {4{LAMP_RED}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_valid_q <= prev_valid_d;
      flash_q      <= flash_d;
      fault_q      <= fault_d;
      fcode_q      <= fcode_d;
      hold_q       <= hold_d;
      lamp_q       <= lamp_d;
    end
  end

  assign hw1_lamp   = lamp_q[0];
  assign hw2_lamp   = lamp_q[1];
  assign fm1_lamp   = lamp_q[2];
  assign fm2_lamp   = lamp_q[3];
  assign hold_req   = hold_q;
  assign fault      = fault_q;
  assign fault_code = fcode_q;

endmodule

// File: doc/traffic_signal_monitor.md
Name: traffic_signal_monitor

Overview:
Downstream safety stage between the traffic-light controller and the physical lamp heads. Takes the four 2-bit signal codes (highway 1/2, farm 1/2) and decodes each into red/amber/green lamp drives. Checks every code for conflicting greens and illegal sequence steps; on any fault it latches into a flashing-amber failsafe and holds the controller via hold_req. It returns to normal service only through an all-red clearance interval.

Parameters:
STARTUP_TICKS, 3, all-red ticks in INIT and CLEAR before RUN (≥1)
WDOG_TICKS, 120, ticks without any code change before a watchdog fault (used only with the macro)
TICK_CNT_W, 7, width of the tick counter; must hold max(STARTUP_TICKS, WDOG_TICKS)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle 1 Hz enable, from the same source as the controller timebase
hw1_code  in  2  highwaySignal1 code
hw2_code  in  2  highwaySignal2 code
fm1_code  in  2  farmSignal1 code
fm2_code  in  2  farmSignal2 code
fault_clr  in  1  operator clear, level-sampled
hw1_lamp, hw2_lamp, fm1_lamp, fm2_lamp  out  3 each  {red, amber, green}
hold_req  out  1  1 = controller must be held in reset (ORed into its rst at top level)
fault  out  1  latched fault flag
fault_code  out  2  0 none, 1 conflict, 2 illegal transition, 3 watchdog

Behaviour:
- Code map: 2 = red (100), 3 = red+amber (110), 0 = green (001), 1 = amber (010).
- "Open" means code 0 or 1.
- Reset:
  - state = INIT, tick counter = 0, all lamps = 100, hold_req = 1.
  - fault = 0, fault_code = 0, prev_valid = 0.
- All outputs are registered. In RUN, a lamp reflects its code one clk after the code is presented.
- INIT:
  - All lamps red, hold_req = 1.
  - Counts ticks. At the cycle where the count reaches STARTUP_TICKS, go to RUN, clear the counter, and set prev_valid = 0.
- RUN:
  - hold_req = 0; lamps = decoded codes.
  - Every cycle, prev code registers load the current codes. prev_valid is set after the first RUN cycle.
  - Conflict: (hw1 or hw2 open) AND (fm1 or fm2 open) in the same cycle.
  - Illegal transition (only when prev_valid): any head with prev ≠ cur and cur ≠ successor(prev). Legal successors: 2→3, 3→0, 0→1, 1→2. Holding the same code is always legal.
  - On detection, go to FAULT the next cycle, set fault = 1, and latch fault_code.
  - Priority when events coincide: conflict > illegal > watchdog.
  - The lamp output for the detecting cycle is already forced to all red; a conflicting green is never driven.
- FAULT:
  - hold_req = 1.
  - All heads show amber only (010) and (000) alternately, toggling on each tick. The phase starts at 010 on entry.
  - Code inputs are ignored. fault and fault_code stay latched.
  - fault_clr = 1: go to CLEAR, zero the counter. fault and fault_code stay latched.
- CLEAR:
  - All red, hold_req = 1.
  - After STARTUP_TICKS ticks, go to RUN, clear fault and fault_code, and set prev_valid = 0.
  - fault_clr during CLEAR has no effect.
- tick coincident with a state change is consumed by the new state's counter; no tick is lost.
- rst mid-operation, from any state: immediately return to the reset values above, including clearing a latched fault.

Optional Feature:
Macro TSM_WATCHDOG_EN.
- Defined:
  - In RUN, a counter increments on each tick and zeroes on any change of any code.
  - Reaching WDOG_TICKS raises fault_code 3 → FAULT.
- Undefined: no watchdog logic exists; fault_code 3 is never produced.

Decomposition:
- Shared package tsm_pkg:
  - state enum {INIT, RUN, FAULT, CLEAR}
  - code constants C_GREEN = 0, C_AMBER = 1, C_RED = 2, C_REDAMB = 3
  - fault-code constants
  - decode function code→3-bit lamp, and successor function
- Sub-module tsm_head_check, instantiated four times: holds prev code, outputs `open` and `illegal`, and the decoded lamp. The top level holds the FSM, tick counters, flash phase, and fault latch.

Test Plan:
- Reset, then 3 ticks with all codes 2 → lamps 100 and hold_req = 1 through tick 3; RUN one cycle after the 3rd tick, hold_req = 0.
- RUN, walk hw1/hw2 2→3→0→1→2 with farm at 2 → hw lamps 100, 110, 001, 010, 100 each one cycle after the code; fault stays 0.
- RUN, hw1 = 0 and fm2 = 0 in the same cycle → next cycle fault = 1, fault_code = 1, all lamps 100, hold_req = 1, then 010/000 toggling per tick.
- RUN, fm1 jumps 2→0 while the highway is red → fault_code = 2.
- Simultaneous conflict and illegal jump → fault_code = 1.
- FAULT, fault_clr pulse → CLEAR, all red for 3 ticks, then RUN with fault = 0 and fault_code = 0.
- rst asserted in FAULT → INIT with fault = 0.
- With TSM_WATCHDOG_EN and WDOG_TICKS = 5, codes frozen in RUN for 5 ticks → fault_code = 3. Without the macro, 200 frozen ticks → no fault.
